// File: rtl/digit_scan_array_pkg.sv
// Shared definitions for the multiplexed digit scanner: code width,
// segment glyph constants (bit7 = a ... bit1 = g, bit0 = dp) and the
// per-digit record held in the pending and display registers.
package digit_scan_array_pkg;

  localparam int CODE_W = 5;

  localparam logic [7:0] GLYPH_0     = 8'b1111_1100;
  localparam logic [7:0] GLYPH_1     = 8'b0110_0000;
  localparam logic [7:0] GLYPH_2     = 8'b1101_1010;
  localparam logic [7:0] GLYPH_3     = 8'b1111_0010;
  localparam logic [7:0] GLYPH_4     = 8'b0110_0110;
  localparam logic [7:0] GLYPH_5     = 8'b1011_0110;
  localparam logic [7:0] GLYPH_6     = 8'b1011_1110;
  localparam logic [7:0] GLYPH_7     = 8'b1110_0000;
  localparam logic [7:0] GLYPH_8     = 8'b1111_1110;
  localparam logic [7:0] GLYPH_9     = 8'b1111_0110;
  localparam logic [7:0] GLYPH_A     = 8'b1110_1110;
  localparam logic [7:0] GLYPH_B     = 8'b0011_1110;
  localparam logic [7:0] GLYPH_C     = 8'b1001_1100;
  localparam logic [7:0] GLYPH_D     = 8'b0111_1010;
  localparam logic [7:0] GLYPH_E     = 8'b1001_1110;
  localparam logic [7:0] GLYPH_F     = 8'b1000_1110;
  localparam logic [7:0] GLYPH_H     = 8'b0110_1110;
  localparam logic [7:0] GLYPH_DP    = 8'b0000_0001;
  localparam logic [7:0] GLYPH_BLANK = 8'b0000_0000;

  localparam logic [CODE_W-1:0] CODE_H = 5'd16;

  // One digit as latched from the load strobe.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              dp;
  } digit_rec_t;

  // Hexadecimal nibble to seven-segment glyph, dp bit clear.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/digit_scan_array_if.sv
// Bus bundle for the digit scanner: display content and brightness in,
// digit select / segment drive / frame marker out.
interface digit_scan_array_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 3
);
  import digit_scan_array_pkg::*;

  logic [CODE_W*DIGITS-1:0] data;
  logic [DIGITS-1:0]        dp_en;
  logic [DIGITS-1:0]        blink_mask;
  logic                     load;
  logic [BRIGHT_W-1:0]      bright;
  logic [DIGITS-1:0]        sel;
  logic [7:0]               driver;
  logic                     frame_sync;

  // Host side: supplies content, observes the scan outputs.
  modport master (
    output data, dp_en, blink_mask, load, bright,
    input  sel, driver, frame_sync
  );

  // Scanner side.
  modport slave (
    input  data, dp_en, blink_mask, load, bright,
    output sel, driver, frame_sync
  );

endinterface

// File: rtl/digit_scan_array_seg_decode.sv
// Combinational code-to-segment decoder for one digit:
// 0-15 hex glyphs, 16 "H", 17-31 decimal point only; dp input ORs bit0.
module seg_decode
  import digit_scan_array_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_dp,
  output logic [7:0]        o_glyph
);

  logic [7:0] w_base;

  // Select the base glyph for the code.
  always_comb begin
    // NOTE: default assigned first so every path drives w_base (no latch).
    w_base = GLYPH_BLANK;
    if (!i_code[CODE_W-1]) begin
      w_base = hex_glyph(i_code[3:0]);
    end else if (i_code == CODE_H) begin
      w_base = GLYPH_H;
    end else begin
      w_base = GLYPH_DP;
    end
  end

  assign o_glyph = w_base | {7'b000_0000, i_dp};

endmodule

// File: rtl/digit_scan_array.sv
// Multiplexed seven-segment scanner. A slot counter divides each digit
// period into SCAN_DIV cycles; the digit index advances on its terminal
// count. Loaded content waits in pending registers and is copied to the
// display registers at the frame boundary so a frame never tears.
// Slot 0 of each digit is always dark to hide select/segment skew, and
// the low BRIGHT_W slot bits against bright give the duty cycle.
// Optional feature macro: DIGIT_SCAN_BLINK_EN (frame-counter blink).
module digit_scan_array
  import digit_scan_array_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16,
  parameter int BRIGHT_W = 3,
  parameter int BLINK_W  = 6
) (
  input logic              per_clk,
  input logic              rst_n,
  digit_scan_array_if.slave bus
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DIG_W  = $clog2(DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

  logic [SLOT_W-1:0] r_slot_cnt;
  logic [DIG_W-1:0]  r_digit;
  digit_rec_t        r_pending [DIGITS];
  digit_rec_t        r_display [DIGITS];
  logic [DIGITS-1:0] r_sel;
  logic [7:0]        r_driver;
  logic              r_frame_sync;

  digit_rec_t        w_in_rec [DIGITS];
  digit_rec_t        w_cur;
  logic              w_slot_last;
  logic              w_frame_end;
  logic              w_blank;
  logic              w_lit;
  logic [7:0]        w_glyph;
  logic [DIGITS-1:0] w_sel_onehot;

  assign w_slot_last  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_end  = w_slot_last && (r_digit == DIG_LAST);
  assign w_sel_onehot = DIGITS'(1) << r_digit;

  // Split the flat input bus into per-digit records.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_in_rec[i].code = bus.data[CODE_W*i +: CODE_W];
      w_in_rec[i].dp   = bus.dp_en[i];
    end
  end

  // Scan position: slot within the digit, then the digit index.
  always_ff @(posedge per_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_digit    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_last) begin
        r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
      end
    end
  end

  // Pending capture on load; display handoff at the frame boundary, where a
  // load in that same cycle bypasses pending and lands immediately.
  always_ff @(posedge per_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these register arrays are reset explicitly because a reset
      // must discard queued content and blank the display, not just the
      // control path.
      for (int i = 0; i < DIGITS; i++) begin
        r_pending[i] <= '0;
        r_display[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.load) begin
          r_pending[i] <= w_in_rec[i];
        end
        if (w_frame_end) begin
          r_display[i] <= bus.load ? w_in_rec[i] : r_pending[i];
        end
      end
    end
  end

`ifdef DIGIT_SCAN_BLINK_EN
  logic [BLINK_W-1:0] r_frame_cnt;
  logic [DIGITS-1:0]  r_blink_pend;
  logic [DIGITS-1:0]  r_blink_disp;

  // Blink masks share the pending/display handoff; frames are counted at the boundary.
  always_ff @(posedge per_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt  <= '0;
      r_blink_pend <= '0;
      r_blink_disp <= '0;
    end else begin
      if (bus.load) begin
        r_blink_pend <= bus.blink_mask;
      end
      if (w_frame_end) begin
        r_blink_disp <= bus.load ? bus.blink_mask : r_blink_pend;
        r_frame_cnt  <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Upper half of the frame-count cycle blanks the flagged digits.
  assign w_blank = r_frame_cnt[BLINK_W-1] & r_blink_disp[r_digit];
`else
  localparam int UNUSED_BLINK_W = BLINK_W;
  logic w_unused_blink;

  // Blink is compiled out: the mask input is accepted but has no effect.
  assign w_unused_blink = ^bus.blink_mask;
  assign w_blank        = 1'b0;
`endif

  // Single decoder on the currently scanned digit.
  assign w_cur = r_display[r_digit];

  seg_decode u_seg_decode (
    .i_code  (w_cur.code),
    .i_dp    (w_cur.dp),
    .o_glyph (w_glyph)
  );

  // Dark in slot 0, then lit while the low slot bits are within the duty level.
  assign w_lit = (r_slot_cnt != '0)
              && (r_slot_cnt[BRIGHT_W-1:0] <= bus.bright)
              && !w_blank;

  // Registered outputs, one cycle behind the scan position they describe.
  always_ff @(posedge per_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= DIGITS'(1);
      r_driver     <= '0;
      r_frame_sync <= 1'b0;
    end else begin
      r_sel        <= w_sel_onehot;
      r_driver     <= w_lit ? w_glyph : GLYPH_BLANK;
      r_frame_sync <= (r_digit == '0) && (r_slot_cnt == '0);
    end
  end

  assign bus.sel        = r_sel;
  assign bus.driver     = r_driver;
  assign bus.frame_sync = r_frame_sync;

endmodule

// File: tb/tb_digit_scan_array.sv
// Self-checking bench for digit_scan_array (DIGITS=4, SCAN_DIV=8, BRIGHT_W=3,
// BLINK_W=2). A frame-position reference model predicts sel/driver/frame_sync
// from cycle counts since reset; directed tasks also check fixed values.
`timescale 1ns/1ps
module tb_digit_scan_array;
  import digit_scan_array_pkg::*;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int BRIGHT_W = 3;
  localparam int BLINK_W  = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic per_clk = 1'b0;
  logic rst_n;

  always #5 per_clk = ~per_clk;

  digit_scan_array_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  digit_scan_array #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BRIGHT_W (BRIGHT_W),
    .BLINK_W  (BLINK_W)
  ) dut (
    .per_clk (per_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference glyphs written out independently of the design package.
  logic [7:0] glyph_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  function automatic logic [7:0] ref_glyph(int code, bit dp);
    logic [7:0] g;
    if (code < 16)       g = glyph_tbl[code];
    else if (code == 16) g = 8'h6E;
    else                 g = 8'h01;
    if (dp) g[0] = 1'b1;
    return g;
  endfunction

  // ---------------- reference model ----------------
  int  m_cyc;
  int  m_frame;
  int  m_pend_code [DIGITS];
  int  m_disp_code [DIGITS];
  bit  m_pend_dp   [DIGITS];
  bit  m_disp_dp   [DIGITS];
  bit  m_pend_blk  [DIGITS];
  bit  m_disp_blk  [DIGITS];
  logic [DIGITS-1:0] exp_sel;
  logic [7:0]        exp_drv;
  logic              exp_fs;

  initial begin
    int  pos;
    int  d;
    int  s;
    bit  dark;
    forever begin
      @(posedge per_clk or negedge rst_n);
      if (!rst_n) begin
        m_cyc   = 0;
        m_frame = 0;
        for (int i = 0; i < DIGITS; i++) begin
          m_pend_code[i] = 0; m_disp_code[i] = 0;
          m_pend_dp[i]   = 0; m_disp_dp[i]   = 0;
          m_pend_blk[i]  = 0; m_disp_blk[i]  = 0;
        end
        exp_sel = DIGITS'(1);
        exp_drv = 8'h00;
        exp_fs  = 1'b0;
      end else begin
        pos  = m_cyc % FRAME;
        d    = pos / SCAN_DIV;
        s    = pos % SCAN_DIV;
        dark = 1'b0;
`ifdef DIGIT_SCAN_BLINK_EN
        dark = m_disp_blk[d] && ((m_frame % (1 << BLINK_W)) >= (1 << (BLINK_W - 1)));
`endif
        exp_sel = DIGITS'(1) << d;
        exp_drv = (s != 0 && (s % (1 << BRIGHT_W)) <= int'(bus.bright) && !dark)
                  ? ref_glyph(m_disp_code[d], m_disp_dp[d]) : 8'h00;
        exp_fs  = (pos == 0);
        if (bus.load) begin
          for (int i = 0; i < DIGITS; i++) begin
            m_pend_code[i] = int'(bus.data[5*i +: 5]);
            m_pend_dp[i]   = bus.dp_en[i];
            m_pend_blk[i]  = bus.blink_mask[i];
          end
        end
        if (pos == FRAME - 1) begin
          for (int i = 0; i < DIGITS; i++) begin
            m_disp_code[i] = m_pend_code[i];
            m_disp_dp[i]   = m_pend_dp[i];
            m_disp_blk[i]  = m_pend_blk[i];
          end
          m_frame++;
        end
        m_cyc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [5*DIGITS-1:0] all_code(int code);
    logic [5*DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[5*i +: 5] = 5'(code);
    return v;
  endfunction

  function automatic logic [5*DIGITS-1:0] rand_data();
    logic [5*DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[5*i +: 5] = 5'($urandom_range(0, 31));
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the load was sampled.
  task automatic do_load(input logic [5*DIGITS-1:0] d, input logic [DIGITS-1:0] dp,
                         input logic [DIGITS-1:0] blk);
    bus.data       = d;
    bus.dp_en      = dp;
    bus.blink_mask = blk;
    bus.load       = 1'b1;
    @(negedge per_clk);
    bus.load       = 1'b0;
  endtask

  // Advance to the negedge showing output cycle 0 of the next frame (model timing).
  task automatic wait_frame_start();
    int k;
    k = 0;
    @(negedge per_clk);
    while (!exp_fs && k < 2 * FRAME) begin
      @(negedge per_clk);
      k++;
    end
    if (!exp_fs) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_start_timeout: waited %0d cycles, required frame start within %0d", k, 2 * FRAME);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n          = 1'b0;
    bus.data       = '0;
    bus.dp_en      = '0;
    bus.blink_mask = '0;
    bus.load       = 1'b0;
    bus.bright     = '0;
    repeat (3) @(negedge per_clk);
    n_vec++;
    if ({bus.sel, bus.driver, bus.frame_sync} !== {4'b0001, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got sel=%b drv=%b fs=%b required sel=0001 drv=00000000 fs=0",
               bus.sel, bus.driver, bus.frame_sync);
    end
    rst_n = 1'b1;
    @(negedge per_clk);
    n_vec++;
    if ({bus.sel, bus.driver, bus.frame_sync} !== {4'b0001, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL first_frame_sync: got sel=%b drv=%b fs=%b required sel=0001 drv=00000000 fs=1",
               bus.sel, bus.driver, bus.frame_sync);
    end
  endtask

  task automatic test_digits();
    logic [7:0] tbl [4];
    logic [7:0] want;
    tbl = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010};
    bus.bright = 3'd7;
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
    wait_frame_start();
    for (int c = 0; c < FRAME; c++) begin
      want = (c % SCAN_DIV == 0) ? 8'h00 : tbl[c / SCAN_DIV];
      n_vec++;
      if ({bus.sel, bus.driver, bus.frame_sync} !== {4'(1 << (c / SCAN_DIV)), want, 1'(c == 0)}) begin
        n_err++;
        $display("FAIL digits_c%0d: got sel=%b drv=%b fs=%b required sel=%b drv=%b fs=%b", c,
                 bus.sel, bus.driver, bus.frame_sync, 4'(1 << (c / SCAN_DIV)), want, c == 0);
      end
      @(negedge per_clk);
    end
  endtask

  task automatic test_bright();
    logic [7:0] want;
    bus.bright = 3'd2;
    do_load(all_code(8), 4'b0000, 4'b0000);
    wait_frame_start();
    for (int c = 0; c < SCAN_DIV; c++) begin
      want = (c == 1 || c == 2) ? 8'b11111110 : 8'h00;
      n_vec++;
      if (bus.driver !== want || bus.driver !== exp_drv) begin
        n_err++;
        $display("FAIL bright2_slot%0d: got %b required %b (model %b)", c, bus.driver, want, exp_drv);
      end
      @(negedge per_clk);
    end
  endtask

  task automatic test_h_dp();
    bus.bright = 3'd7;
    do_load({5'd0, 5'd0, 5'd20, 5'd16}, 4'b0011, 4'b0000);
    wait_frame_start();
    @(negedge per_clk);
    n_vec++;
    if (bus.driver !== 8'b01101111) begin
      n_err++;
      $display("FAIL code16_dp: got %b required 01101111", bus.driver);
    end
    repeat (SCAN_DIV) @(negedge per_clk);
    n_vec++;
    if (bus.driver !== 8'b00000001) begin
      n_err++;
      $display("FAIL code20_dp: got %b required 00000001", bus.driver);
    end
  endtask

  task automatic test_load_timing();
    logic [7:0] want;
    bus.bright = 3'd7;
    do_load(all_code(1), 4'b0000, 4'b0000);
    wait_frame_start();                       // c = 0, showing code 1
    repeat (10) @(negedge per_clk);           // c = 10
    do_load(all_code(5), 4'b0000, 4'b0000);   // c = 11
    repeat (4) @(negedge per_clk);            // c = 15
    do_load(all_code(9), 4'b0000, 4'b0000);   // c = 16
    bus.data = all_code(7);                   // changes without load
    for (int c = 16; c < FRAME; c++) begin
      want = (c % SCAN_DIV == 0) ? 8'h00 : 8'h60;
      n_vec++;
      if (bus.driver !== want) begin
        n_err++;
        $display("FAIL hold_old_c%0d: got %b required %b", c, bus.driver, want);
      end
      @(negedge per_clk);
    end
    n_vec++;
    if ({bus.sel, bus.frame_sync} !== {4'b0001, 1'b1}) begin
      n_err++;
      $display("FAIL load_frame_sync: got sel=%b fs=%b required sel=0001 fs=1", bus.sel, bus.frame_sync);
    end
    @(negedge per_clk);
    n_vec++;
    if (bus.driver !== 8'hF6) begin
      n_err++;
      $display("FAIL last_load_wins: got %b required 11110110", bus.driver);
    end
    wait_frame_start();
    @(negedge per_clk);
    n_vec++;
    if (bus.driver !== 8'hF6) begin
      n_err++;
      $display("FAIL data_without_load: got %b required 11110110", bus.driver);
    end
  endtask

  task automatic test_boundary_load();
    bus.bright = 3'd7;
    wait_frame_start();                       // c = 0
    repeat (FRAME - 2) @(negedge per_clk);    // c = 30, counter now in boundary cycle
    do_load(all_code(10), 4'b0000, 4'b0000);  // c = 31
    @(negedge per_clk);
    @(negedge per_clk);                       // c = 1 of next frame
    n_vec++;
    if (bus.driver !== 8'hEE) begin
      n_err++;
      $display("FAIL boundary_load: got %b required 11101110", bus.driver);
    end
  endtask

  task automatic test_blink();
    int lit;
    int want_lit;
    lit = 0;
    bus.bright = 3'd7;
    do_load(all_code(8), 4'b0000, 4'b0010);
    wait_frame_start();
    repeat (SCAN_DIV + 1) @(negedge per_clk); // digit 1, slot 1
    for (int f = 0; f < 8; f++) begin
      n_vec++;
      if (bus.driver !== exp_drv) begin
        n_err++;
        $display("FAIL blink_frame%0d: got %b required %b", f, bus.driver, exp_drv);
      end
      if (bus.driver != 8'h00) lit++;
      repeat (FRAME) @(negedge per_clk);
    end
`ifdef DIGIT_SCAN_BLINK_EN
    want_lit = 4;
`else
    want_lit = 8;
`endif
    n_vec++;
    if (lit != want_lit) begin
      n_err++;
      $display("FAIL blink_lit_count: got %0d lit frames required %0d of 8", lit, want_lit);
    end
  endtask

  task automatic test_random();
    bus.bright = 3'd7;
    for (int k = 0; k < 20 * FRAME; k++) begin
      if ($urandom_range(0, 63) == 0) bus.bright = BRIGHT_W'($urandom);
      bus.data       = rand_data();
      bus.dp_en      = DIGITS'($urandom);
      bus.blink_mask = DIGITS'($urandom);
      bus.load       = ($urandom_range(0, 9) == 0);
      @(negedge per_clk);
      n_vec++;
      if ({bus.sel, bus.driver, bus.frame_sync} !== {exp_sel, exp_drv, exp_fs}) begin
        n_err++;
        $display("FAIL random_k%0d: got sel=%b drv=%b fs=%b required sel=%b drv=%b fs=%b", k,
                 bus.sel, bus.driver, bus.frame_sync, exp_sel, exp_drv, exp_fs);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.bright = 3'd7;
    wait_frame_start();                       // c = 0
    repeat (3) @(negedge per_clk);            // c = 3
    do_load(all_code(5), 4'b0000, 4'b0000);   // c = 4, pending only
    repeat (16) @(negedge per_clk);           // c = 20: counter at digit 2, slot 5
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.sel, bus.driver, bus.frame_sync} !== {4'b0001, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_immediate: got sel=%b drv=%b fs=%b required sel=0001 drv=00000000 fs=0",
               bus.sel, bus.driver, bus.frame_sync);
    end
    @(negedge per_clk);
    rst_n = 1'b1;
    @(negedge per_clk);
    n_vec++;
    if ({bus.sel, bus.driver, bus.frame_sync} !== {4'b0001, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL reset_restart: got sel=%b drv=%b fs=%b required sel=0001 drv=00000000 fs=1",
               bus.sel, bus.driver, bus.frame_sync);
    end
    @(negedge per_clk);
    n_vec++;
    if (bus.driver !== 8'hFC) begin
      n_err++;
      $display("FAIL reset_shows_zero: got %b required 11111100", bus.driver);
    end
    wait_frame_start();
    @(negedge per_clk);
    n_vec++;
    if (bus.driver !== 8'hFC) begin
      n_err++;
      $display("FAIL reset_drops_pending: got %b required 11111100", bus.driver);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_bright();
    test_h_dp();
    test_load_timing();
    test_boundary_load();
    test_blink();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/digit_scan_array.md
DIGIT_SCAN_ARRAY -- requirements
Module: digit_scan_array

Interface
REQ-001 Parameter DIGITS, 4, number of multiplexed digits (2..8).
REQ-002 Parameter SCAN_DIV, 16, per_clk cycles per digit slot (power of two, >= 2^BRIGHT_W).
REQ-003 Parameter BRIGHT_W, 3, brightness control width.
REQ-004 Parameter BLINK_W, 6, blink frame-counter width.
REQ-005 Port per_clk  in  1  sole clock, rising edge; reset is asynchronous, active-low.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port data  in  5*DIGITS  per-digit code, digit i at bits [5i+4:5i].
REQ-008 Port dp_en  in  DIGITS  per-digit decimal-point enable.
REQ-009 Port blink_mask  in  DIGITS  per-digit blink enable.
REQ-010 Port load  in  1  single-cycle strobe capturing data/dp_en/blink_mask into pending registers.
REQ-011 Port bright  in  BRIGHT_W  duty level; all ones = full on.
REQ-012 Port sel  out  DIGITS  one-hot active-high digit select.
REQ-013 Port driver  out  8  segments a..g,dp (bit7=a, bit0=dp), active-high.
REQ-014 Port frame_sync  out  1  one-cycle pulse at each frame start.

Function
REQ-015 slot_cnt SHALL count 0..SCAN_DIV-1 and wrap; at terminal count digit index SHALL advance, DIGITS-1 wrapping to 0.
REQ-016 sel SHALL be one-hot on the current digit index, changing in the cycle after slot_cnt terminal count.
REQ-017 Decode: codes 0-15 SHALL map to hex glyphs 0-F, 16 to "H", 17-31 to dp-only 8'b00000001.
REQ-018 dp_en[i] SHALL OR bit0 of the digit-i glyph.
REQ-019 driver SHALL be 0 when slot_cnt==0 (ghosting guard), else glyph when slot_cnt[BRIGHT_W-1:0] <= bright, else 0.
REQ-020 Outputs sel, driver, frame_sync SHALL be registered; driver reflects slot_cnt/digit state with one-cycle latency.
REQ-021 load SHALL write pending registers; multiple loads before a frame boundary: last wins.
REQ-022 Pending SHALL copy to display registers at frame boundary (digit index wrapping to 0); load in the boundary cycle SHALL take effect at that boundary.
REQ-023 frame_sync SHALL pulse high exactly one cycle when digit 0 is selected after wrap.
REQ-024 Data changes without load SHALL have no visible effect.

Reset
REQ-025 rst_n low SHALL immediately force: sel = one-hot digit 0, driver = 0, frame_sync = 0, all counters 0, pending and display registers 0.
REQ-026 Reset mid-frame SHALL discard pending loads; first frame after release starts at digit 0, slot_cnt 0.

Configuration
REQ-027 Macro DIGIT_SCAN_BLINK_EN defined: BLINK_W-bit frame counter increments each frame; while its MSB is 1, digits with display blink_mask set SHALL drive 0.
REQ-028 Macro undefined: blink counter absent, blink_mask port present but ignored, no digit blanked by blink.

Structure
REQ-029 Shared package SHALL hold glyph constants (0-F, H, DP, BLANK) and the 5-bit code width.
REQ-030 Sub-module seg_decode (5-bit code + dp -> 8-bit glyph, combinational) SHALL be instantiated once on the muxed digit.

Verification
REQ-031 DIGITS=4, SCAN_DIV=8, bright=7, load data={3,2,1,0}: sel cycles 0001,0010,0100,1000 each 8 cycles; driver 11111100,01100000,11011010,11110010 except slot 0 = 0.
REQ-032 bright=2, code 8: per slot driver 0 at slot_cnt 0, 11111110 at slot_cnt 1-2, 0 at slot_cnt 3-7.
REQ-033 Codes 16 and 20 with dp_en=1: driver 01101111 and 00000001.
REQ-034 Load 5 mid-frame, then 9, no further load: display changes only at next frame_sync, showing 9.
REQ-035 Assert rst_n low at digit 2 slot_cnt 5: same-cycle sel=0001, driver=0; after release frame restarts at digit 0, display shows 0 until load.
REQ-036 DIGIT_SCAN_BLINK_EN, BLINK_W=2, blink_mask=0010: digit 1 dark on frames 2-3 of each 4, lit on frames 0-1; without macro always lit.
